// File: rtl/debug_frame_parser_pkg.sv
// Shared constants and FSM state encoding for the debug frame parser.
package debug_frame_parser_pkg;

  localparam int unsigned DEBUG_DATA_WIDTH = 8;
  localparam int unsigned DEBUG_FRAME_PAYLOAD_LEN = 4;

  localparam logic [DEBUG_DATA_WIDTH-1:0] DEBUG_FRAME_SYNC0 = 8'h5A;
  localparam logic [DEBUG_DATA_WIDTH-1:0] DEBUG_FRAME_SYNC1 = 8'hA5;

  typedef enum logic [4:0] {
    S_SYNC0   = 5'b00001,
    S_SYNC1   = 5'b00010,
    S_PAYLOAD = 5'b00100,
    S_CSUM    = 5'b01000,
    S_HOLD    = 5'b10000
  } state_e;

endpackage

// File: rtl/debug_byte_strobe.sv
// Registers the UART RI flag, detects its rising edge and captures the byte with it.
module debug_byte_strobe
  import debug_frame_parser_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sync_clr_i,
  input  logic                        ri_i,
  input  logic [DEBUG_DATA_WIDTH-1:0] byte_i,
  output logic                        strobe_o,
  output logic [DEBUG_DATA_WIDTH-1:0] byte_o
);

  logic                        ri_q;
  logic                        strobe_q;
  logic [DEBUG_DATA_WIDTH-1:0] byte_q;
  logic                        rise;

  assign rise = ri_i & ~ri_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ri_q     <= 1'b0;
      strobe_q <= 1'b0;
      byte_q   <= '0;
    end else if (sync_clr_i) begin
      ri_q     <= 1'b0;
      strobe_q <= 1'b0;
      byte_q   <= '0;
    end else begin
      ri_q     <= ri_i;
      strobe_q <= rise;
      if (rise) begin
        byte_q <= byte_i;
      end
    end
  end

  assign strobe_o = strobe_q;
  assign byte_o   = byte_q;

endmodule

// File: rtl/debug_frame_parser.sv
// Debug frame parser: 5A A5 CMD AH AL DATA CSUM with zero-sum checksum.
// Define DEBUG_FRAME_TIMEOUT_EN to build the inter-byte timeout.
module debug_frame_parser
  import debug_frame_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sync_reset,
  input  logic                        RI,
  input  logic [DEBUG_DATA_WIDTH-1:0] SBUF_out,
  input  logic                        frame_ack,
  output logic                        frame_valid,
  output logic [7:0]                  cmd,
  output logic [7:0]                  addr_hi,
  output logic [7:0]                  addr_lo,
  output logic [7:0]                  data,
  output logic                        csum_err_pulse,
  output logic                        overrun_pulse,
  output logic                        timeout_pulse
);

  logic       strobe;
  logic [7:0] rx_byte;
  logic [7:0] csum_chk;
  logic       tmo_fire;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] cmd_q, cmd_d, addr_hi_q, addr_hi_d, addr_lo_q, addr_lo_d, data_q, data_d;
  logic       valid_q, valid_d, csum_err_q, csum_err_d, overrun_q, overrun_d, tmo_q, tmo_d;

  debug_byte_strobe u_strobe (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .sync_clr_i (sync_reset),
    .ri_i       (RI),
    .byte_i     (SBUF_out),
    .strobe_o   (strobe),
    .byte_o     (rx_byte)
  );

  assign csum_chk = sum_q + rx_byte;

`ifdef DEBUG_FRAME_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            waiting;

  assign waiting  = (state_q == S_SYNC1) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign tmo_fire = waiting && !strobe && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = (waiting && !strobe && !tmo_fire) ? tmo_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (sync_reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    cmd_d      = cmd_q;
    addr_hi_d  = addr_hi_q;
    addr_lo_d  = addr_lo_q;
    data_d     = data_q;
    valid_d    = valid_q;
    csum_err_d = 1'b0;
    overrun_d  = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      S_SYNC0: begin
        if (strobe && rx_byte == DEBUG_FRAME_SYNC0) state_d = S_SYNC1;
      end
      S_SYNC1: begin
        if (strobe) begin
          if (rx_byte == DEBUG_FRAME_SYNC1) begin
            state_d = S_PAYLOAD;
            idx_d   = '0;
            sum_d   = '0;
          end else if (rx_byte != DEBUG_FRAME_SYNC0) begin
            state_d = S_SYNC0;
          end
        end
      end
      S_PAYLOAD: begin
        if (strobe) begin
          unique case (idx_q)
            2'd0: cmd_d     = rx_byte;
            2'd1: addr_hi_d = rx_byte;
            2'd2: addr_lo_d = rx_byte;
            2'd3: data_d    = rx_byte;
            default: ;
          endcase
          sum_d = csum_chk;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(DEBUG_FRAME_PAYLOAD_LEN - 1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (strobe) begin
          if (csum_chk == 8'h00) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d    = S_SYNC0;
            csum_err_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // A byte arriving with the ack is still dropped; ack takes priority.
        overrun_d = strobe;
        if (frame_ack) begin
          state_d = S_SYNC0;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_SYNC0;
    endcase
    if (tmo_fire) begin
      state_d = S_SYNC0;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_SYNC0;
      idx_q      <= '0;
      sum_q      <= '0;
      cmd_q      <= '0;
      addr_hi_q  <= '0;
      addr_lo_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      csum_err_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else if (sync_reset) begin
      state_q    <= S_SYNC0;
      idx_q      <= '0;
      sum_q      <= '0;
      cmd_q      <= '0;
      addr_hi_q  <= '0;
      addr_lo_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      csum_err_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      cmd_q      <= cmd_d;
      addr_hi_q  <= addr_hi_d;
      addr_lo_q  <= addr_lo_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      csum_err_q <= csum_err_d;
      overrun_q  <= overrun_d;
      tmo_q      <= tmo_d;
    end
  end

  assign frame_valid    = valid_q;
  assign cmd            = cmd_q;
  assign addr_hi        = addr_hi_q;
  assign addr_lo        = addr_lo_q;
  assign data           = data_q;
  assign csum_err_pulse = csum_err_q;
  assign overrun_pulse  = overrun_q;
  assign timeout_pulse  = tmo_q;

endmodule

// File: tb/tb_debug_frame_parser.sv
// Directed bench for debug_frame_parser; honours DEBUG_FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=50.
module tb_debug_frame_parser;
  import debug_frame_parser_pkg::*;

`ifdef DEBUG_FRAME_TIMEOUT_EN
  localparam int Gap1 = 20;
`else
  localparam int Gap1 = 2000;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_reset = 1'b0;
  logic       RI = 1'b0;
  logic [7:0] SBUF_out = 8'h00;
  logic       frame_ack = 1'b0;
  logic       frame_valid, csum_err_pulse, overrun_pulse, timeout_pulse;
  logic [7:0] cmd, addr_hi, addr_lo, data;

  int total = 0;
  int bad = 0;
  int n_csum = 0, n_over = 0, n_tmo = 0, n_frames = 0;
  int s_csum, s_over, s_tmo, s_frames;
  logic fv_prev = 1'b0;

  debug_frame_parser #(.TIMEOUT_CYCLES(50)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_reset     (sync_reset),
    .RI             (RI),
    .SBUF_out       (SBUF_out),
    .frame_ack      (frame_ack),
    .frame_valid    (frame_valid),
    .cmd            (cmd),
    .addr_hi        (addr_hi),
    .addr_lo        (addr_lo),
    .data           (data),
    .csum_err_pulse (csum_err_pulse),
    .overrun_pulse  (overrun_pulse),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  // Counts high cycles of each pulse, so a stuck pulse shows up as an extra count.
  always @(negedge clk) begin
    if (csum_err_pulse) n_csum++;
    if (overrun_pulse) n_over++;
    if (timeout_pulse) n_tmo++;
    if (frame_valid && !fv_prev) n_frames++;
    fv_prev = frame_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_csum = n_csum; s_over = n_over; s_tmo = n_tmo; s_frames = n_frames;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    SBUF_out = b;
    RI = 1'b1;
    repeat (2) @(negedge clk);
    RI = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] d, input logic [7:0] s);
    send_byte(8'h5A, 6); send_byte(8'hA5, 6);
    send_byte(c, 6); send_byte(h, 6); send_byte(l, 6); send_byte(d, 6); send_byte(s, 6);
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_fields", {cmd, addr_hi, addr_lo, data}, 32'h0);
    chk("reset_pulses", {29'd0, csum_err_pulse, overrun_pulse, timeout_pulse}, 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(S_SYNC0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1; the zero-sum checksum for payload 01 12 34 56 is 0x63.
    snap();
    send_byte(8'h5A, Gap1); send_byte(8'hA5, Gap1); send_byte(8'h01, Gap1);
    send_byte(8'h12, Gap1); send_byte(8'h34, Gap1); send_byte(8'h56, Gap1);
    @(negedge clk);
    SBUF_out = 8'h63;
    RI = 1'b1;
    @(posedge clk); #1;
    chk("lat_strobe_cycle", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, frame_valid}, 32'd1);
    @(negedge clk);
    RI = 1'b0;
    repeat (4) @(negedge clk);
    chk("f1_fields", {cmd, addr_hi, addr_lo, data}, 32'h01123456);
    chk("f1_no_pulses", 32'((n_csum - s_csum) + (n_over - s_over) + (n_tmo - s_tmo)), 32'd0);
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk); #1;
    chk("ack_valid_low", {31'd0, frame_valid}, 32'd0);
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_state", 32'(dut.state_q), 32'(S_SYNC0));

    // Bad checksum, then a good frame (21+43+65+87 = 0x150, csum 0xB0).
    snap();
    send_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h66);
    chk("csum_err_cnt", 32'(n_csum - s_csum), 32'd1);
    chk("csum_err_valid", {31'd0, frame_valid}, 32'd0);
    chk("csum_err_state", 32'(dut.state_q), 32'(S_SYNC0));
    send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hB0);
    chk("after_err_valid", {31'd0, frame_valid}, 32'd1);
    chk("after_err_fields", {cmd, addr_hi, addr_lo, data}, 32'h21436587);
    ack();

    // Repeated sync byte, then ack and byte landing on the same edge.
    snap();
    send_byte(8'h5A, 6);
    send_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h63);
    chk("resync_frames", 32'(n_frames - s_frames), 32'd1);
    @(negedge clk);
    SBUF_out = 8'h44;
    RI = 1'b1;
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    RI = 1'b0;
    repeat (4) @(negedge clk);
    chk("ackbyte_overrun", 32'(n_over - s_over), 32'd1);
    chk("ackbyte_valid", {31'd0, frame_valid}, 32'd0);
    chk("ackbyte_state", 32'(dut.state_q), 32'(S_SYNC0));

    // Bad first sync byte: nothing reported.
    snap();
    send_byte(8'h00, 6); send_byte(8'hA5, 6); send_byte(8'h01, 6); send_byte(8'h12, 6);
    send_byte(8'h34, 6); send_byte(8'h56, 6); send_byte(8'h63, 6);
    chk("nosync_frames", 32'(n_frames - s_frames), 32'd0);
    chk("nosync_state", 32'(dut.state_q), 32'(S_SYNC0));

    // Overrun while holding (7F+00+FF+80 = 0x1FE, csum 0x02).
    snap();
    send_frame(8'h7F, 8'h00, 8'hFF, 8'h80, 8'h02);
    send_byte(8'h77, 6);
    chk("ovr_cnt", 32'(n_over - s_over), 32'd1);
    chk("ovr_fields", {cmd, addr_hi, addr_lo, data}, 32'h7F00FF80);
    chk("ovr_valid", {31'd0, frame_valid}, 32'd1);
    ack();
    chk("ovr_ack_valid", {31'd0, frame_valid}, 32'd0);

    // Ack outside hold is ignored; then the inter-byte timeout window.
    snap();
    send_byte(8'h5A, 6); send_byte(8'hA5, 6);
    ack();
    chk("stray_ack_state", 32'(dut.state_q), 32'(S_PAYLOAD));
    send_byte(8'h01, 60);
`ifdef DEBUG_FRAME_TIMEOUT_EN
    chk("tmo_cnt", 32'(n_tmo - s_tmo), 32'd1);
    chk("tmo_state", 32'(dut.state_q), 32'(S_SYNC0));
    send_byte(8'h12, 6); send_byte(8'h34, 6); send_byte(8'h56, 6); send_byte(8'h63, 6);
    chk("tmo_frames", 32'(n_frames - s_frames), 32'd0);
`else
    chk("tmo_cnt", 32'(n_tmo - s_tmo), 32'd0);
    chk("tmo_state", 32'(dut.state_q), 32'(S_PAYLOAD));
    send_byte(8'h12, 6); send_byte(8'h34, 6); send_byte(8'h56, 6); send_byte(8'h63, 6);
    chk("tmo_frames", 32'(n_frames - s_frames), 32'd1);
    ack();
`endif

    // Async reset mid-frame (AA+BB+CC+DD = 0x30E, csum 0xF2).
    snap();
    send_byte(8'h5A, 6); send_byte(8'hA5, 6); send_byte(8'h01, 6); send_byte(8'h12, 6);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fields", {cmd, addr_hi, addr_lo, data}, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(S_SYNC0));
    reset_n = 1'b1;
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF2);
    chk("rst_frames", 32'(n_frames - s_frames), 32'd1);
    chk("rst_fields2", {cmd, addr_hi, addr_lo, data}, 32'hAABBCCDD);
    chk("rst_no_pulses", 32'((n_csum - s_csum) + (n_over - s_over) + (n_tmo - s_tmo)), 32'd0);
    ack();

    // Synchronous clear mid-frame.
    snap();
    send_byte(8'h5A, 6); send_byte(8'hA5, 6); send_byte(8'h33, 6);
    @(negedge clk);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    chk("srst_state", 32'(dut.state_q), 32'(S_SYNC0));
    chk("srst_cmd", {24'd0, cmd}, 32'd0);
    send_frame(8'h01, 8'h12, 8'h34, 8'h56, 8'h63);
    chk("srst_frames", 32'(n_frames - s_frames), 32'd1);
    chk("srst_no_pulses", 32'((n_csum - s_csum) + (n_over - s_over) + (n_tmo - s_tmo)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
